// File: rtl/hazard_respawn_ctrl_pkg.sv
// Shared types and constants for the hazard / respawn sequence and its users.
package hazard_respawn_ctrl_pkg;

  typedef enum logic [2:0] {
    StAlive,
    StFreeze,
    StRespawn,
    StInvuln,
    StOver
  } hr_state_e;

  localparam int unsigned X_W = 10;
  localparam int unsigned Y_W = 9;

  // Level code and player logic both read these so the spawn point agrees everywhere.
  localparam logic [X_W-1:0] SPAWN_X_DEF = 10'd40;
  localparam logic [Y_W-1:0] SPAWN_Y_DEF = 9'd400;

endpackage

// File: rtl/hazard_respawn_ctrl_frame_timer.sv
// Frame-paced counter: counts frame_tick pulses, pulses done on the tick that reaches term.
module frame_timer #(
  parameter int unsigned CW = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          frame_tick,
  input  logic [CW-1:0] term,
  output logic          done,
  output logic [CW-1:0] count
);

  always_comb begin
    done = frame_tick && !clear && (count == term - CW'(1));
  end

  // Restarting on done keeps the count from ever wrapping.
  always_ff @(posedge clk) begin
    if (reset || clear || done) begin
      count <= '0;
    end else if (frame_tick) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/hazard_respawn_ctrl.sv
// Player hit / freeze / respawn / invulnerability sequencer; owns lives and game-over.
module hazard_respawn_ctrl
  import hazard_respawn_ctrl_pkg::*;
#(
  parameter int unsigned    N_HAZ         = 4,
  parameter int unsigned    LIVES         = 3,
  parameter int unsigned    FREEZE_FRAMES = 60,
  parameter int unsigned    INVULN_FRAMES = 90,
  parameter int unsigned    BLINK_SHIFT   = 3,
  parameter logic [X_W-1:0] SPAWN_X       = SPAWN_X_DEF,
  parameter logic [Y_W-1:0] SPAWN_Y       = SPAWN_Y_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_tick,
  input  logic [N_HAZ-1:0]           touched,
  output logic                       freeze,
  output logic                       sprite_on,
  output logic                       det_clear,
  output logic                       respawn,
  output logic [X_W-1:0]             spawn_x,
  output logic [Y_W-1:0]             spawn_y,
  output logic [2:0]                 lives,
  output logic                       game_over,
  output logic [$clog2(N_HAZ)-1:0]   hit_src
);

  localparam int unsigned MAX_FRAMES =
      (FREEZE_FRAMES > INVULN_FRAMES) ? FREEZE_FRAMES : INVULN_FRAMES;
  localparam int unsigned CW = $clog2(MAX_FRAMES + 1);

  hr_state_e               state;
  logic                    timer_clear;
  logic                    timer_done;
  logic [CW-1:0]           timer_term;
  logic [CW-1:0]           cnt;
  logic [$clog2(N_HAZ)-1:0] hit_idx;

  assign spawn_x = SPAWN_X;
  assign spawn_y = SPAWN_Y;

  // Timer only runs while a timed state is active, so ticks elsewhere are discarded.
  always_comb begin
    timer_clear = !((state == StFreeze) || (state == StInvuln));
    timer_term  = (state == StInvuln) ? CW'(INVULN_FRAMES) : CW'(FREEZE_FRAMES);
  end

  always_comb begin
    hit_idx = '0;
    for (int i = N_HAZ - 1; i >= 0; i--) begin
      if (touched[i]) begin
        hit_idx = ($clog2(N_HAZ))'(i);
      end
    end
  end

  frame_timer #(
    .CW(CW)
  ) u_frame_timer (
    .clk        (clk),
    .reset      (reset),
    .clear      (timer_clear),
    .frame_tick (frame_tick),
    .term       (timer_term),
    .done       (timer_done),
    .count      (cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StAlive;
      lives     <= 3'(LIVES);
      hit_src   <= '0;
      freeze    <= 1'b0;
      sprite_on <= 1'b1;
      det_clear <= 1'b0;
      respawn   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      respawn <= 1'b0;
      unique case (state)
        StAlive: begin
          if (|touched) begin
            state   <= StFreeze;
            hit_src <= hit_idx;
            lives   <= (lives == 3'd0) ? 3'd0 : lives - 3'd1;
            freeze  <= 1'b1;
          end
        end
        StFreeze: begin
          if (timer_done) begin
            if (lives == 3'd0) begin
              state     <= StOver;
              sprite_on <= 1'b0;
              game_over <= 1'b1;
            end else begin
              state     <= StRespawn;
              det_clear <= 1'b1;
              respawn   <= 1'b1;
            end
          end
        end
        StRespawn: begin
          state     <= StInvuln;
          freeze    <= 1'b0;
          sprite_on <= 1'b1;
        end
        StInvuln: begin
          if (timer_done) begin
            state     <= StAlive;
            sprite_on <= 1'b1;
            det_clear <= 1'b0;
          end else begin
            sprite_on <= ~cnt[BLINK_SHIFT];
          end
        end
        StOver: begin
        end
        default: begin
          state <= StAlive;
        end
      endcase
    end
  end

endmodule
